mem_responder: RTL and testbench

//  Memory-side responder for the CPU's read/write strobe interface (mem_rd/mem_wr, 5-bit addr, 8-bit data).

---
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: CPU-side memory with configurable wait states and a loader port.
// Each level-held request is served once. rsp_ready pulses WAIT_STATES+1 cycles
// after the accept edge, and the request must drop before the next accept.
module mem_responder #(
    parameter int AWIDTH      = 5,
    parameter int DWIDTH      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_ready,
    output logic              busy,
    output logic              req_err,
    input  logic              load_we,
    input  logic [AWIDTH-1:0] load_addr,
    input  logic [DWIDTH-1:0] load_data
);

    // state   | meaning
    // IDLE    | ready to accept; loader writes only land here
    // WAIT    | counting down wait states
    // DONE    | one cycle: commit write or capture read data, pulse rsp_ready
    // RELEASE | wait for both strobes low before returning to IDLE
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_RELEASE} state_t;

    localparam logic [3:0] WS_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [DWIDTH-1:0] mem_q [2**AWIDTH];

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic              is_wr_q;
    logic [DWIDTH-1:0] rsp_rdata_q;
    logic              rsp_ready_q;
    logic              busy_q;
    logic              req_err_q;

    logic              mem_we_d;
    logic [AWIDTH-1:0] mem_waddr_d;
    logic [DWIDTH-1:0] mem_wdata_d;

    // Store write port: loader in IDLE, CPU write commit in DONE; nothing during reset.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_waddr_d = load_addr;
        mem_wdata_d = load_data;
        if (!rst) begin
            if (state_q == S_IDLE && load_we) begin
                mem_we_d = 1'b1;
            end else if (state_q == S_DONE && is_wr_q) begin
                mem_we_d    = 1'b1;
                mem_waddr_d = addr_q;
                mem_wdata_d = wdata_q;
            end
        end
    end

    // Storage array, deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
    end

    // Request sequencing FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            rsp_rdata_q <= '0;
            rsp_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            req_err_q   <= 1'b0;
        end else begin
            rsp_ready_q <= 1'b0;
            req_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A loader write takes the cycle; the CPU request is retried next cycle.
                    if (!load_we) begin
                        if (req_rd && req_wr) begin
                            req_err_q <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= S_RELEASE;
                        end else if (req_rd || req_wr) begin
                            addr_q  <= req_addr;
                            wdata_q <= req_wdata;
                            is_wr_q <= req_wr;
                            busy_q  <= 1'b1;
                            if (WAIT_STATES == 0) begin
                                state_q <= S_DONE;
                            end else begin
                                cnt_q   <= WS_INIT;
                                state_q <= S_WAIT;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    rsp_ready_q <= 1'b1;
                    if (!is_wr_q) begin
                        rsp_rdata_q <= mem_q[addr_q];
                    end
                    state_q <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!req_rd && !req_wr) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_ready = rsp_ready_q;
    assign busy      = busy_q;
    assign req_err   = req_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with WAIT_STATES=1.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_rd, req_wr;
    logic [4:0] req_addr;
    logic [7:0] req_wdata;
    logic [7:0] rsp_rdata;
    logic       rsp_ready, busy, req_err;
    logic       load_we;
    logic [4:0] load_addr;
    logic [7:0] load_data;

    int vec  = 0;
    int errs = 0;

    mem_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst),
        .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_rdata(rsp_rdata), .rsp_ready(rsp_ready), .busy(busy), .req_err(req_err),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] a, input logic [7:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        tick();
        load_we = 1'b0;
    endtask

    // Runs one CPU access; lat counts edges from the accept edge (inclusive) to rsp_ready,
    // bc counts cycles with busy high across the whole transaction.
    task automatic access(input logic wr, input logic [4:0] a, input logic [7:0] wd,
                          output logic [7:0] rd, output int lat, output int bc);
        req_rd = !wr; req_wr = wr; req_addr = a; req_wdata = wd;
        lat = 0; bc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (busy) bc++;
            if (rsp_ready) break;
        end
        rd = rsp_rdata;
        req_rd = 1'b0; req_wr = 1'b0;
        tick();
        if (busy) bc++;
    endtask

    initial begin
        logic [7:0] d;
        int lat, bc, pulses;

        rst = 1'b1; req_rd = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
        load_we = 0; load_addr = 0; load_data = 0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_ready", rsp_ready, 0);
        chk("reset_rdata", rsp_rdata, 0);

        // Load then read, one wait state.
        load(5'd5, 8'h3C);
        access(1'b0, 5'd5, 8'h00, d, lat, bc);
        chk("load_read_data", d, 8'h3C);
        chk("load_read_latency", lat - 1, 2);
        chk("load_read_busy_cycles", bc, 3);
        chk("idle_after_release", busy, 0);

        // Reset mid-WAIT, store contents survive.
        load(5'd3, 8'hA5);
        req_rd = 1'b1; req_addr = 5'd7;
        tick();
        chk("in_wait_busy", busy, 1);
        rst = 1'b1;
        tick(); tick();
        req_rd = 1'b0;
        rst = 1'b0;
        chk("midwait_reset_busy", busy, 0);
        chk("midwait_reset_ready", rsp_ready, 0);
        chk("midwait_reset_rdata", rsp_rdata, 0);
        access(1'b0, 5'd3, 8'h00, d, lat, bc);
        chk("store_survives_reset", d, 8'hA5);

        // Write at top address, read back, neighbour at 0 untouched.
        load(5'd0, 8'h11);
        access(1'b1, 5'd31, 8'hFF, d, lat, bc);
        chk("write_latency", lat - 1, 2);
        access(1'b0, 5'd31, 8'h00, d, lat, bc);
        chk("write_read_back", d, 8'hFF);
        access(1'b0, 5'd0, 8'h00, d, lat, bc);
        chk("addr0_unchanged", d, 8'h11);

        // Held strobe served once; a fresh assert is served again.
        req_rd = 1'b1; req_addr = 5'd5;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (rsp_ready) pulses++; end
        chk("held_one_pulse", pulses, 1);
        req_rd = 1'b0;
        tick();
        req_rd = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (rsp_ready) pulses++; end
        chk("reassert_second_pulse", pulses, 1);
        req_rd = 1'b0;
        tick();

        // Conflicting strobes.
        load(5'd2, 8'h5A);
        req_rd = 1'b1; req_wr = 1'b1; req_addr = 5'd2; req_wdata = 8'h00;
        tick();
        chk("conflict_err", req_err, 1);
        chk("conflict_busy", busy, 1);
        pulses = 0;
        tick();
        chk("conflict_err_one_cycle", req_err, 0);
        for (int i = 0; i < 5; i++) begin if (rsp_ready) pulses++; tick(); end
        chk("conflict_no_ready", pulses, 0);
        req_rd = 1'b0; req_wr = 1'b0;
        tick();
        access(1'b0, 5'd2, 8'h00, d, lat, bc);
        chk("conflict_store_unchanged", d, 8'h5A);

        // Loader wins the IDLE cycle; the read follows one cycle later.
        load_we = 1'b1; load_addr = 5'd9; load_data = 8'h77;
        req_rd = 1'b1; req_addr = 5'd9;
        tick();
        load_we = 1'b0;
        chk("loader_priority_idle", busy, 0);
        lat = 0;
        for (int i = 0; i < 20; i++) begin tick(); lat++; if (rsp_ready) break; end
        chk("loader_then_read_latency", lat - 1, 2);
        chk("loader_then_read_data", rsp_rdata, 8'h77);
        req_rd = 1'b0;
        tick();

        // Loader writes are dropped while busy.
        load(5'd10, 8'h44);
        req_rd = 1'b1; req_addr = 5'd10;
        tick();
        load_we = 1'b1; load_addr = 5'd10; load_data = 8'h99;
        tick();
        load_we = 1'b0;
        for (int i = 0; i < 20; i++) begin if (rsp_ready) break; tick(); end
        chk("wait_load_read_data", rsp_rdata, 8'h44);
        req_rd = 1'b0;
        tick();
        access(1'b0, 5'd10, 8'h00, d, lat, bc);
        chk("wait_load_dropped", d, 8'h44);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
